// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and frame helpers
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int parity_en, input int stop_bits);
    return 1 + DATA_BITS + parity_en + stop_bits;
  endfunction

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: clr restarts a bit period, bit_tick marks the last
// clock of each period and the count reloads itself so periods never drift.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_tick
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: restart on clr, otherwise count down and wrap at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = RELOAD;
    end else if (en) begin
      if (cnt_q == 16'd0) begin
        cnt_d = RELOAD;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = en && (cnt_q == 16'd0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a shift register that
// serialises start, 8 data bits LSB-first, optional parity and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] THR,
  input  logic       thr_wr,
  output logic       thr_empty,
  output logic       tx_busy,
  output logic       tx_ovr,
  output logic       tx_pin
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       ODD_SENSE = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  uart_state_e state_q, state_d;
  logic [7:0]  thr_q, thr_d;
  logic        thr_full_q, thr_full_d;
  logic [7:0]  tsr_q, tsr_d;
  logic        par_q, par_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        tx_pin_q, tx_pin_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic        bit_tick_s;
  logic        load_s;
  logic        frame_done_s;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load_s),
    .en       (state_q != IDLE),
    .bit_tick (bit_tick_s)
  );

  assign frame_done_s = (state_q == STOP) && bit_tick_s && (bit_cnt_q == LAST_STOP);
  // A full holding register starts a frame from idle or straight off the last stop clock.
  assign load_s = thr_full_q && ((state_q == IDLE) || frame_done_s);

  // Next-state, line and holding-register logic.
  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    tsr_d      = tsr_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    tx_pin_d   = tx_pin_q;
    busy_d     = busy_q;
    ovr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        tx_pin_d = 1'b1;
        busy_d   = 1'b0;
      end
      START: begin
        if (bit_tick_s) begin
          state_d   = DATA;
          tx_pin_d  = tsr_q[0];
          tsr_d     = {1'b0, tsr_q[7:1]};
          bit_cnt_d = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_tick_s) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = 3'd0;
            if (PARITY_EN != 0) begin
              state_d  = PARITY;
              tx_pin_d = par_q;
            end else begin
              state_d  = STOP;
              tx_pin_d = 1'b1;
            end
          end else begin
            tx_pin_d  = tsr_q[0];
            tsr_d     = {1'b0, tsr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_tick_s) begin
          state_d   = STOP;
          tx_pin_d  = 1'b1;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (frame_done_s) begin
          state_d  = IDLE;
          tx_pin_d = 1'b1;
          busy_d   = 1'b0;
        end else if (bit_tick_s) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_pin_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase

    if (load_s) begin
      state_d    = START;
      tsr_d      = thr_q;
      par_d      = parity_bit(thr_q, ODD_SENSE);
      thr_full_d = 1'b0;
      bit_cnt_d  = 3'd0;
      tx_pin_d   = 1'b0;
      busy_d     = 1'b1;
    end else begin
      par_d = par_q;
    end

    // Acceptance looks at the pre-edge full flag, so a write never bypasses a transfer.
    if (thr_wr && thr_full_q) begin
      ovr_d = 1'b1;
    end else if (thr_wr) begin
      thr_d      = THR;
      thr_full_d = 1'b1;
    end else begin
      ovr_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      thr_q      <= 8'h00;
      thr_full_q <= 1'b0;
      tsr_q      <= 8'h00;
      par_q      <= 1'b0;
      bit_cnt_q  <= 3'd0;
      tx_pin_q   <= 1'b1;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      tsr_q      <= tsr_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_pin_q   <= tx_pin_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign thr_empty = ~thr_full_q;
  assign tx_busy   = busy_q;
  assign tx_ovr    = ovr_q;
  assign tx_pin    = tx_pin_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations driven from a write
// schedule and compared per clock against a frame-level reference model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] thr;
  logic [3:0] wr;
  logic pin0, pin1, pin2, pin3;
  logic busy0, busy1, busy2, busy3;
  logic empty0, empty1, empty2, empty3;
  logic ovr0, ovr1, ovr2, ovr3;

  int n_checks = 0;
  int n_fail = 0;

  int         sched_c[$];
  logic [7:0] sched_b[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  logic       rx_st, rx_sp;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(5)) dut0 (.clk(clk), .rst_n(rst_n), .THR(thr), .thr_wr(wr[0]),
    .thr_empty(empty0), .tx_busy(busy0), .tx_ovr(ovr0), .tx_pin(pin0));
  uart_tx #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (.clk(clk), .rst_n(rst_n),
    .THR(thr), .thr_wr(wr[1]), .thr_empty(empty1), .tx_busy(busy1), .tx_ovr(ovr1), .tx_pin(pin1));
  uart_tx #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(0)) dut2 (.clk(clk), .rst_n(rst_n),
    .THR(thr), .thr_wr(wr[2]), .thr_empty(empty2), .tx_busy(busy2), .tx_ovr(ovr2), .tx_pin(pin2));
  uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut3 (.clk(clk), .rst_n(rst_n), .THR(thr),
    .thr_wr(wr[3]), .thr_empty(empty3), .tx_busy(busy3), .tx_ovr(ovr3), .tx_pin(pin3));

  function automatic int cfg_cpb(input int i);
    return (i == 3) ? 3 : 5;
  endfunction
  function automatic int cfg_pe(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_odd(input int i);
    return (i == 1) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int i);
    return (9 + cfg_pe(i) + cfg_sb(i)) * cfg_cpb(i);
  endfunction

  // Line level for bit period k of a frame carrying byte b.
  function automatic logic exp_bit(input int i, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && cfg_pe(i) == 1) return 1'((($countones(b) % 2) + cfg_odd(i)) % 2);
    return 1'b1;
  endfunction

  task automatic sample(input int i, output logic p, output logic bs, output logic em, output logic ov);
    case (i)
      0: begin p = pin0; bs = busy0; em = empty0; ov = ovr0; end
      1: begin p = pin1; bs = busy1; em = empty1; ov = ovr1; end
      2: begin p = pin2; bs = busy2; em = empty2; ov = ovr2; end
      3: begin p = pin3; bs = busy3; em = empty3; ov = ovr3; end
      default: begin p = 1'bx; bs = 1'bx; em = 1'bx; ov = 1'bx; end
    endcase
  endtask

  task automatic check_idle(input string name);
    logic p, bs, em, ov;
    for (int i = 0; i < 4; i++) begin
      sample(i, p, bs, em, ov);
      n_checks += 4;
      if (p !== 1'b1) begin n_fail++; $display("FAIL %s tx_pin inst%0d: got %b want 1", name, i, p); end
      if (bs !== 1'b0) begin n_fail++; $display("FAIL %s tx_busy inst%0d: got %b want 0", name, i, bs); end
      if (em !== 1'b1) begin n_fail++; $display("FAIL %s thr_empty inst%0d: got %b want 1", name, i, em); end
      if (ov !== 1'b0) begin n_fail++; $display("FAIL %s tx_ovr inst%0d: got %b want 0", name, i, ov); end
    end
  endtask

  // Drive sched_c/sched_b into one instance and compare every clock with the model.
  task automatic run_sched(input int inst, input string name);
    int fs[$];
    int fa[$];
    logic [7:0] fb[$];
    int dr[$];
    int len, line_free, pend, ncyc, c, s;
    logic p, bs, em, ov, ep, ebs, eem, eov;
    len = frame_len(inst);
    line_free = 0;
    pend = -1;
    ncyc = 0;
    for (int j = 0; j < sched_c.size(); j++) begin
      c = sched_c[j];
      if (pend >= c) begin
        dr.push_back(c);
      end else begin
        s = (c + 1 > line_free) ? c + 1 : line_free;
        fs.push_back(s); fa.push_back(c); fb.push_back(sched_b[j]);
        pend = s;
        line_free = s + len;
      end
      if (c + 2 > ncyc) ncyc = c + 2;
    end
    if (line_free + 2 > ncyc) ncyc = line_free + 2;

    @(negedge clk);
    for (int e = 0; e < ncyc; e++) begin
      thr = 8'($urandom);
      wr = 4'b0000;
      for (int j = 0; j < sched_c.size(); j++) begin
        if (sched_c[j] == e) begin thr = sched_b[j]; wr[inst] = 1'b1; end
      end
      @(posedge clk);
      #1;
      wr = 4'b0000;
      thr = 8'($urandom);
      ep = 1'b1; ebs = 1'b0; eem = 1'b1; eov = 1'b0;
      for (int f = 0; f < fs.size(); f++) begin
        if (e >= fs[f] && e < fs[f] + len) begin
          ep = exp_bit(inst, fb[f], (e - fs[f]) / cfg_cpb(inst));
          ebs = 1'b1;
        end
        if (e >= fa[f] && e < fs[f]) eem = 1'b0;
      end
      for (int d = 0; d < dr.size(); d++) if (dr[d] == e) eov = 1'b1;
      sample(inst, p, bs, em, ov);
      n_checks += 4;
      if (p !== ep) begin n_fail++; $display("FAIL %s tx_pin inst%0d edge%0d: got %b want %b", name, inst, e, p, ep); end
      if (bs !== ebs) begin n_fail++; $display("FAIL %s tx_busy inst%0d edge%0d: got %b want %b", name, inst, e, bs, ebs); end
      if (em !== eem) begin n_fail++; $display("FAIL %s thr_empty inst%0d edge%0d: got %b want %b", name, inst, e, em, eem); end
      if (ov !== eov) begin n_fail++; $display("FAIL %s tx_ovr inst%0d edge%0d: got %b want %b", name, inst, e, ov, eov); end
      @(negedge clk);
    end
  endtask

  task automatic set_sched(input int c0, input logic [7:0] b0);
    sched_c.delete(); sched_b.delete();
    sched_c.push_back(c0); sched_b.push_back(b0);
  endtask

  task automatic add_sched(input int c0, input logic [7:0] b0);
    sched_c.push_back(c0); sched_b.push_back(b0);
  endtask

  // Mid-bit receiver on instance 0's line for the loopback scenario.
  initial begin
    forever begin
      @(negedge pin0);
      repeat (2) @(posedge clk);
      #1 rx_st = pin0;
      for (int k = 0; k < 8; k++) begin
        repeat (5) @(posedge clk);
        #1 rx_b[k] = pin0;
      end
      repeat (5) @(posedge clk);
      #1 rx_sp = pin0;
      if (!rx_st && rx_sp) rx_q.push_back(rx_b);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; wr = 4'b0000; thr = 8'h00;
    #12;
    check_idle("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("reset_release");
  endtask

  task automatic test_single();
    set_sched(0, 8'h35);
    run_sched(0, "single_35");
  endtask

  task automatic test_back_to_back();
    set_sched(0, 8'hA5); add_sched(10, 8'h3C);
    run_sched(0, "b2b");
    set_sched(0, 8'h96); add_sched(4, 8'h0F);
    run_sched(3, "b2b_2stop");
  endtask

  task automatic test_overrun();
    set_sched(0, 8'h11); add_sched(3, 8'h22); add_sched(6, 8'h33);
    run_sched(0, "overrun");
  endtask

  task automatic test_parity();
    set_sched(0, 8'h35);
    run_sched(1, "parity_odd");
    set_sched(0, 8'h35);
    run_sched(2, "parity_even");
    set_sched(0, 8'hC1); add_sched(2, 8'h80);
    run_sched(1, "parity_odd_b2b");
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b[4];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h35; exp_b[3] = 8'hC3;
    rx_q.delete();
    set_sched(0, exp_b[0]);
    for (int j = 1; j < 4; j++) add_sched(2 + (j - 1) * 50, exp_b[j]);
    run_sched(0, "loopback");
    n_checks++;
    if (rx_q.size() != 4) begin
      n_fail++; $display("FAIL loopback_count: got %0d bytes want 4", rx_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (rx_q[j] !== exp_b[j]) begin
          n_fail++; $display("FAIL loopback_byte%0d: got %02h want %02h", j, rx_q[j], exp_b[j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    thr = 8'h5A; wr = 4'b0001;
    @(negedge clk);
    wr = 4'b0000;
    @(negedge clk);
    thr = 8'hEE; wr = 4'b0001;
    @(negedge clk);
    wr = 4'b0000;
    repeat (20) @(posedge clk);
    #2;
    n_checks += 2;
    if (pin0 !== 1'b1) begin n_fail++; $display("FAIL reset_mid_bit3: got %b want 1", pin0); end
    if (empty0 !== 1'b0) begin n_fail++; $display("FAIL reset_mid_thr_full: got %b want 0", empty0); end
    rst_n = 1'b0;
    #1;
    check_idle("reset_mid_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_sched(0, 8'h81);
    run_sched(0, "after_reset_81");
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 4; i++) begin
      sched_c.delete(); sched_b.delete();
      c = int'($urandom_range(0, 3));
      for (int n = 0; n < 6; n++) begin
        add_sched(c, 8'($urandom));
        c += int'($urandom_range(1, frame_len(i) + 5));
      end
      run_sched(i, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_parity();
    test_loopback();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
